// File: rtl/micro_pkg.sv
// Shared definitions for the microprogram sequencer: uop bit positions, next-address
// control codes, fixed micro-addresses, the microword layout and the opcode dispatch map.
package micro_pkg;

    localparam int UADDR_W = 6;

    localparam int U_NOP1 = 0;
    localparam int U_ARPC = 1;
    localparam int U_PCIN = 2;
    localparam int U_RDRS = 3;
    localparam int U_ARRS = 4;
    localparam int U_ARRD = 5;
    localparam int U_RDPC = 6;
    localparam int U_PCRS = 7;
    localparam int U_NOP2 = 8;
    localparam int U_IRM  = 9;
    localparam int U_MRS  = 10;
    localparam int U_RDM  = 11;
    localparam int U_PLUS = 12;
    localparam int U_MINU = 13;
    localparam int U_RDIN = 14;
    localparam int U_OTRS = 15;

    typedef enum logic [1:0] {
        NCTL_NEXT = 2'b00,
        NCTL_JUMP = 2'b01,
        NCTL_MAP  = 2'b10,
        NCTL_WAIT = 2'b11
    } nctl_e;

    localparam logic [UADDR_W-1:0] UA_IDLE  = UADDR_W'(0);
    localparam logic [UADDR_W-1:0] UA_FETCH = UADDR_W'(1);
    localparam logic [UADDR_W-1:0] UA_ILL   = UADDR_W'(16);

    typedef struct packed {
        logic [15:0]        uop;
        nctl_e              nctl;
        logic [UADDR_W-1:0] naddr;
    } uword_t;

    function automatic logic [15:0] ubit(input int idx);
        return 16'h0001 << idx;
    endfunction

    function automatic uword_t mk_word(input logic [15:0] uop, input nctl_e nctl,
                                       input logic [UADDR_W-1:0] naddr);
        uword_t w;
        w.uop   = uop;
        w.nctl  = nctl;
        w.naddr = naddr;
        return w;
    endfunction

    function automatic logic op_illegal(input logic [3:0] op);
        return (op >= 4'hA) && (op <= 4'hE);
    endfunction

    function automatic logic [UADDR_W-1:0] op_map(input logic [3:0] op);
        logic [UADDR_W-1:0] ua;
        case (op)
            4'h0:    ua = UADDR_W'(4);
            4'h1:    ua = UADDR_W'(5);
            4'h2:    ua = UADDR_W'(6);
            4'h3:    ua = UADDR_W'(8);
            4'h4:    ua = UADDR_W'(10);
            4'h5:    ua = UADDR_W'(11);
            4'h6:    ua = UADDR_W'(12);
            4'h7:    ua = UADDR_W'(13);
            4'h8:    ua = UADDR_W'(14);
            4'h9:    ua = UADDR_W'(15);
            4'hF:    ua = UA_IDLE;
            default: ua = UA_ILL;
        endcase
        return ua;
    endfunction

endpackage

// File: rtl/ucode_rom.sv
// Combinational control store: micro-address in, microword out.
// Unlisted addresses fall back to a harmless nop1 that jumps to idle.
module ucode_rom
    import micro_pkg::*;
#(
    parameter int UA_W = UADDR_W
) (
    input  logic [UA_W-1:0] addr,
    output uword_t          word
);

    always_comb begin
        word = mk_word(ubit(U_NOP1), NCTL_JUMP, UA_IDLE);
        case (int'(addr))
            0:  word = mk_word(ubit(U_NOP1), NCTL_WAIT, UA_IDLE);
            1:  word = mk_word(ubit(U_ARPC), NCTL_NEXT, UA_IDLE);
            2:  word = mk_word(ubit(U_IRM),  NCTL_NEXT, UA_IDLE);
            3:  word = mk_word(ubit(U_PCIN) | ubit(U_NOP2), NCTL_MAP, UA_IDLE);
            4:  word = mk_word(ubit(U_NOP2), NCTL_JUMP, UA_FETCH);
            5:  word = mk_word(ubit(U_RDRS), NCTL_JUMP, UA_FETCH);
            6:  word = mk_word(ubit(U_ARRS), NCTL_NEXT, UA_IDLE);
            7:  word = mk_word(ubit(U_RDM),  NCTL_JUMP, UA_FETCH);
            8:  word = mk_word(ubit(U_ARRD), NCTL_NEXT, UA_IDLE);
            9:  word = mk_word(ubit(U_MRS),  NCTL_JUMP, UA_FETCH);
            10: word = mk_word(ubit(U_PLUS), NCTL_JUMP, UA_FETCH);
            11: word = mk_word(ubit(U_MINU), NCTL_JUMP, UA_FETCH);
            12: word = mk_word(ubit(U_RDIN), NCTL_JUMP, UA_FETCH);
            13: word = mk_word(ubit(U_OTRS), NCTL_JUMP, UA_FETCH);
            14: word = mk_word(ubit(U_PCRS), NCTL_JUMP, UA_FETCH);
            15: word = mk_word(ubit(U_RDPC), NCTL_JUMP, UA_FETCH);
            16: word = mk_word(ubit(U_NOP2), NCTL_JUMP, UA_IDLE);
            default: ;
        endcase
    end

endmodule

// File: rtl/micro_seq.sv
// Microprogram sequencer: micro-PC, stall/timeout tracking, sticky error flags and the
// next-address mux driven by the microword's nctl field.
module micro_seq
    import micro_pkg::*;
#(
    parameter int UA_W = UADDR_W,
    parameter int TMO  = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [3:0]      ir_op,
    input  logic            mem_rdy,
    input  logic            in_vld,
    input  logic            out_rdy,
    output logic [15:0]     uop,
    output logic [UA_W-1:0] upc,
    output logic            busy,
    output logic            illegal,
    output logic            timeout
);

    localparam int             CNT_W    = (TMO > 1) ? $clog2(TMO + 1) : 1;
    localparam bit             TMO_EN   = (TMO > 0);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TMO > 0) ? TMO - 1 : 0);

    logic [UA_W-1:0]  upc_q, upc_d;
    logic [CNT_W-1:0] stall_cnt, stall_cnt_d;
    logic             illegal_q, illegal_d;
    logic             timeout_q, timeout_d;
    logic             stall;
    uword_t           uw;

    ucode_rom #(.UA_W(UA_W)) u_rom (
        .addr (upc_q),
        .word (uw)
    );

    // A handshake seen in the same cycle as its op completes it, so only ~ready stalls.
    assign stall = ((uw.uop[U_IRM] | uw.uop[U_RDM] | uw.uop[U_MRS]) & ~mem_rdy)
                 | (uw.uop[U_RDIN] & ~in_vld)
                 | (uw.uop[U_OTRS] & ~out_rdy);

    always_comb begin
        upc_d       = upc_q;
        stall_cnt_d = '0;
        illegal_d   = illegal_q;
        timeout_d   = timeout_q;
        if (stall) begin
            if (TMO_EN && (stall_cnt == TMO_LAST)) begin
                upc_d     = UA_W'(UA_IDLE);
                timeout_d = 1'b1;
            end else begin
                stall_cnt_d = stall_cnt + 1'b1;
            end
        end else begin
            case (uw.nctl)
                NCTL_NEXT: upc_d = upc_q + 1'b1;
                NCTL_JUMP: upc_d = UA_W'(uw.naddr);
                NCTL_MAP: begin
                    upc_d = UA_W'(op_map(ir_op));
                    if (op_illegal(ir_op))
                        illegal_d = 1'b1;
                end
                NCTL_WAIT: begin
                    // Only word 0 waits, so start is naturally ignored while busy.
                    if (start) begin
                        upc_d     = UA_W'(UA_FETCH);
                        illegal_d = 1'b0;
                        timeout_d = 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            upc_q     <= '0;
            stall_cnt <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            upc_q     <= upc_d;
            stall_cnt <= stall_cnt_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    assign uop     = uw.uop;
    assign upc     = upc_q;
    assign busy    = (upc_q != '0);
    assign illegal = illegal_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_micro_seq.sv
// Bench for micro_seq: directed scenarios plus a randomized run checked against a
// routine-level model (queues of expected micro-steps per instruction).
module tb_micro_seq;

    logic        clk = 1'b0;
    logic        rst, start, mem_rdy, in_vld, out_rdy;
    logic [3:0]  ir_op;
    logic [15:0] uop;
    logic [5:0]  upc;
    logic        busy, illegal, timeout;

    int n_chk = 0;
    int n_fail = 0;

    micro_seq #(.UA_W(6), .TMO(8)) dut (
        .clk(clk), .rst(rst), .start(start), .ir_op(ir_op), .mem_rdy(mem_rdy),
        .in_vld(in_vld), .out_rdy(out_rdy), .uop(uop), .upc(upc), .busy(busy),
        .illegal(illegal), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          addr;
        logic [15:0] u;
    } ent_t;

    ent_t q[$];

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_fetch;
        q.push_back('{1, 16'h0002});
        q.push_back('{2, 16'h0200});
        q.push_back('{3, 16'h0104});
    endtask

    task automatic push_exec(input logic [3:0] op);
        case (op)
            4'h0: q.push_back('{4, 16'h0100});
            4'h1: q.push_back('{5, 16'h0008});
            4'h2: begin q.push_back('{6, 16'h0010}); q.push_back('{7, 16'h0800}); end
            4'h3: begin q.push_back('{8, 16'h0020}); q.push_back('{9, 16'h0400}); end
            4'h4: q.push_back('{10, 16'h1000});
            4'h5: q.push_back('{11, 16'h2000});
            4'h6: q.push_back('{12, 16'h4000});
            4'h7: q.push_back('{13, 16'h8000});
            4'h8: q.push_back('{14, 16'h0080});
            4'h9: q.push_back('{15, 16'h0040});
            4'hF: ;
            default: q.push_back('{16, 16'h0100});
        endcase
    endtask

    function automatic bit stalls(input logic [15:0] u, input logic mr, input logic iv,
                                  input logic orr);
        if ((u == 16'h0200 || u == 16'h0800 || u == 16'h0400) && !mr) return 1;
        if (u == 16'h4000 && !iv) return 1;
        if (u == 16'h8000 && !orr) return 1;
        return 0;
    endfunction

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; ir_op = 4'h0;
        mem_rdy = 1'b1; in_vld = 1'b1; out_rdy = 1'b1;
        tick; tick;
        rst = 1'b0;
        n_chk++;
        if ({upc, uop, busy, illegal, timeout} !== {6'd0, 16'h0001, 3'b000}) begin
            n_fail++;
            $display("FAIL reset: upc=%0d uop=%h busy=%b ill=%b tmo=%b, want 0 0001 0 0 0",
                     upc, uop, busy, illegal, timeout);
        end
    endtask

    task automatic test_fetch_add;
        int          ea[4] = '{2, 3, 10, 1};
        logic [15:0] eu[4] = '{16'h0200, 16'h0104, 16'h1000, 16'h0002};
        ir_op = 4'h4;
        start = 1'b1;
        n_chk++;
        if (busy !== 1'b0 || upc !== 6'd0) begin
            n_fail++; $display("FAIL start_idle: upc=%0d busy=%b, want 0 0", upc, busy);
        end
        tick;
        start = 1'b0;
        n_chk++;
        if (upc !== 6'd1 || uop !== 16'h0002 || busy !== 1'b1) begin
            n_fail++; $display("FAIL fetch1: upc=%0d uop=%h busy=%b, want 1 0002 1", upc, uop, busy);
        end
        for (int i = 0; i < 4; i++) begin
            tick;
            n_chk++;
            if (upc !== 6'(ea[i]) || uop !== eu[i]) begin
                n_fail++; $display("FAIL add_step%0d: upc=%0d uop=%h, want %0d %h", i, upc, uop, ea[i], eu[i]);
            end
        end
    endtask

    task automatic test_ld_stall;
        int ea[4] = '{2, 3, 6, 7};
        ir_op = 4'h2;
        for (int i = 0; i < 4; i++) begin
            tick;
            n_chk++;
            if (upc !== 6'(ea[i])) begin
                n_fail++; $display("FAIL ld_step%0d: upc=%0d, want %0d", i, upc, ea[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            mem_rdy = (i == 3);
            n_chk++;
            if (upc !== 6'd7 || uop !== 16'h0800) begin
                n_fail++; $display("FAIL ld_hold%0d: upc=%0d uop=%h, want 7 0800", i, upc, uop);
            end
            tick;
        end
        n_chk++;
        if (upc !== 6'd1) begin
            n_fail++; $display("FAIL ld_done: upc=%0d, want 1", upc);
        end
    endtask

    task automatic test_illegal;
        ir_op = 4'hB;
        tick; tick; tick;
        n_chk++;
        if (upc !== 6'd16 || illegal !== 1'b1) begin
            n_fail++; $display("FAIL ill_map: upc=%0d ill=%b, want 16 1", upc, illegal);
        end
        tick;
        n_chk++;
        if (upc !== 6'd0 || busy !== 1'b0 || illegal !== 1'b1) begin
            n_fail++; $display("FAIL ill_idle: upc=%0d busy=%b ill=%b, want 0 0 1", upc, busy, illegal);
        end
        start = 1'b1; tick; start = 1'b0;
        n_chk++;
        if (upc !== 6'd1 || illegal !== 1'b0) begin
            n_fail++; $display("FAIL ill_clear: upc=%0d ill=%b, want 1 0", upc, illegal);
        end
    endtask

    task automatic test_timeout;
        ir_op = 4'h7;
        out_rdy = 1'b0;
        tick; tick; tick;
        for (int i = 0; i < 8; i++) begin
            n_chk++;
            if (upc !== 6'd13 || uop !== 16'h8000 || timeout !== 1'b0) begin
                n_fail++; $display("FAIL tmo_hold%0d: upc=%0d uop=%h tmo=%b, want 13 8000 0", i, upc, uop, timeout);
            end
            tick;
        end
        n_chk++;
        if (upc !== 6'd0 || timeout !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL tmo_abort: upc=%0d tmo=%b busy=%b, want 0 1 0", upc, timeout, busy);
        end
        out_rdy = 1'b1;
        start = 1'b1; tick; start = 1'b0;
        n_chk++;
        if (upc !== 6'd1 || timeout !== 1'b0) begin
            n_fail++; $display("FAIL tmo_clear: upc=%0d tmo=%b, want 1 0", upc, timeout);
        end
    endtask

    task automatic test_halt_rst;
        ir_op = 4'hF;
        tick; tick; tick;
        n_chk++;
        if (upc !== 6'd0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL halt: upc=%0d busy=%b, want 0 0", upc, busy);
        end
        start = 1'b1; tick;
        n_chk++;
        if (upc !== 6'd1) begin
            n_fail++; $display("FAIL halt_restart: upc=%0d, want 1", upc);
        end
        tick; start = 1'b0;
        n_chk++;
        if (upc !== 6'd2) begin
            n_fail++; $display("FAIL start_busy: upc=%0d, want 2", upc);
        end
        ir_op = 4'h2;
        tick; tick;
        n_chk++;
        if (upc !== 6'd6) begin
            n_fail++; $display("FAIL pre_rst: upc=%0d, want 6", upc);
        end
        rst = 1'b1; tick; rst = 1'b0;
        n_chk++;
        if (upc !== 6'd0 || uop !== 16'h0001 || busy !== 1'b0) begin
            n_fail++; $display("FAIL mid_rst: upc=%0d uop=%h busy=%b, want 0 0001 0", upc, uop, busy);
        end
    endtask

    task automatic test_random;
        bit          m_idle = 1, m_ill = 0, m_tmo = 0, slow = 0;
        int          scnt = 0;
        logic [3:0]  op = 4'h0;
        ent_t        e, h;
        int          lim;
        q.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            lim = slow ? 15 : 3;
            mem_rdy = ($urandom_range(0, lim) == 0) ? 1'b0 : 1'b1;
            in_vld  = ($urandom_range(0, lim) == 0) ? 1'b0 : 1'b1;
            out_rdy = ($urandom_range(0, lim) == 0) ? 1'b0 : 1'b1;
            if (slow) begin
                mem_rdy = ($urandom_range(0, 15) == 0);
                in_vld  = ($urandom_range(0, 15) == 0);
                out_rdy = ($urandom_range(0, 15) == 0);
            end
            start = m_idle ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
            ir_op = op;
            e = m_idle ? '{0, 16'h0001} : q[0];
            n_chk++;
            if (upc !== 6'(e.addr) || uop !== e.u || busy !== !m_idle ||
                illegal !== m_ill || timeout !== m_tmo) begin
                n_fail++;
                $display("FAIL rand c%0d: upc=%0d uop=%h busy=%b ill=%b tmo=%b, want %0d %h %b %b %b",
                         cyc, upc, uop, busy, illegal, timeout, e.addr, e.u, !m_idle, m_ill, m_tmo);
            end
            if (m_idle) begin
                if (start) begin
                    m_idle = 0; m_ill = 0; m_tmo = 0;
                    push_fetch();
                end
            end else if (stalls(q[0].u, mem_rdy, in_vld, out_rdy)) begin
                scnt++;
                if (scnt == 8) begin
                    q.delete(); m_idle = 1; m_tmo = 1; scnt = 0;
                end
            end else begin
                scnt = 0;
                h = q.pop_front();
                if (h.addr == 3) begin
                    if (op >= 4'hA && op <= 4'hE) m_ill = 1;
                    push_exec(op);
                end
                if (q.size() == 0) begin
                    if (h.addr == 16 || (h.addr == 3 && op == 4'hF)) begin
                        m_idle = 1;
                    end else begin
                        op = 4'($urandom_range(0, 15));
                        slow = ($urandom_range(0, 7) == 0);
                        push_fetch();
                    end
                end
            end
            if (m_idle && q.size() == 0) begin
                op = 4'($urandom_range(0, 15));
                slow = ($urandom_range(0, 7) == 0);
            end
            tick;
        end
        start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fetch_add();
        test_ld_stall();
        test_illegal();
        test_timeout();
        test_halt_rst();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
